// File: rtl/accum_store_ctl_pkg.sv
// rtl/accum_store_ctl_pkg.sv - shared types and defaults for the accumulator store path
package accum_store_ctl_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 13;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_TIMEOUT   = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_HOLD  = 2'd3
    } store_state_t;

    // Bits needed for a counter that must be able to hold max_val
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/accum_store_ctl_store_wdog.sv
// rtl/accum_store_ctl_store_wdog.sv - up-counter with loadable terminal count for setup dwell and write timeout
module accum_store_ctl_store_wdog #(
    parameter int CNT_W = 4
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] tc_val;

    // Count register and terminal value; clear takes priority over increment
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            tc_val <= '0;
        end else begin
            if (load) begin
                tc_val <= load_val;
            end
            if (clr) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/accum_store_ctl.sv
// rtl/accum_store_ctl.sv - snapshots the accumulator on a store request and writes it over the bus
module accum_store_ctl
    import accum_store_ctl_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic [DATA_W-1:0] accum,
    input  logic              accum_valid,
    input  logic              sto_req,
    input  logic [ADDR_W-1:0] sto_addr,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              data_oe,
    output logic              busy,
    output logic              done,
    output logic              err_invalid,
    output logic              err_timeout
);

    // One counter serves both phases, so size it for the larger terminal value
    localparam int CNT_W = cnt_width((TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC);

    store_state_t     state;
    logic             wd_clr;
    logic             wd_en;
    logic             wd_load;
    logic [CNT_W-1:0] wd_load_val;
    logic             wd_tc;

    // Counter control: parked at zero with the setup dwell loaded while idle,
    // re-armed with the timeout on the way into WRITE
    always_comb begin
        wd_clr      = 1'b0;
        wd_en       = 1'b0;
        wd_load     = 1'b0;
        wd_load_val = CNT_W'(SETUP_CYC);
        case (state)
            ST_IDLE: begin
                wd_clr      = 1'b1;
                wd_load     = 1'b1;
                wd_load_val = CNT_W'(SETUP_CYC);
            end
            ST_SETUP: begin
                if (wd_tc) begin
                    wd_clr      = 1'b1;
                    wd_load     = 1'b1;
                    wd_load_val = CNT_W'(TIMEOUT);
                end else begin
                    wd_en = 1'b1;
                end
            end
            ST_WRITE: begin
                wd_en = 1'b1;
            end
            default: begin
                wd_clr = 1'b0;
            end
        endcase
    end

    accum_store_ctl_store_wdog #(
        .CNT_W (CNT_W)
    ) u_wdog (
        .clk1     (clk1),
        .rst      (rst),
        .clr      (wd_clr),
        .en       (wd_en),
        .load     (wd_load),
        .load_val (wd_load_val),
        .tc       (wd_tc)
    );

    // Store sequencer with registered bus outputs and status pulses
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wr      <= 1'b0;
            data_oe     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_invalid <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done        <= 1'b0;
            err_invalid <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sto_req) begin
                        if (accum_valid) begin
                            mem_wdata <= accum;
                            mem_addr  <= sto_addr;
                            data_oe   <= 1'b1;
                            busy      <= 1'b1;
                            state     <= ST_SETUP;
                        end else begin
                            err_invalid <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (wd_tc) begin
                        mem_wr <= 1'b1;
                        state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // An ack on the terminal-count edge still counts as success
                    if (mem_ack) begin
                        mem_wr <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_HOLD;
                    end else if (wd_tc) begin
                        mem_wr      <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    data_oe <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_store_ctl.sv
// tb/tb_accum_store_ctl.sv - self-checking bench for accum_store_ctl
module tb_accum_store_ctl;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 13;
    localparam int SETUP_CYC = 1;
    localparam int TIMEOUT   = 15;

    logic              clk1 = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] accum;
    logic              accum_valid;
    logic              sto_req;
    logic [ADDR_W-1:0] sto_addr;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr;
    logic              data_oe;
    logic              busy;
    logic              done;
    logic              err_invalid;
    logic              err_timeout;

    int vectors     = 0;
    int miscompares = 0;

    accum_store_ctl #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .SETUP_CYC (SETUP_CYC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .accum       (accum),
        .accum_valid (accum_valid),
        .sto_req     (sto_req),
        .sto_addr    (sto_addr),
        .mem_ack     (mem_ack),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wr      (mem_wr),
        .data_oe     (data_oe),
        .busy        (busy),
        .done        (done),
        .err_invalid (err_invalid),
        .err_timeout (err_timeout)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One store transaction. ack_at = WRITE cycle (1-based) in which mem_ack is
    // presented; 0 or beyond the timeout window means no usable ack.
    // Expected timing is derived from the documented latency rules.
    task automatic do_store(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                            input int ack_at, input bit perturb, input bit hold_req,
                            input string tag);
        int wr_cnt   = 0;
        int first_wr = -1;
        int done_t   = -1;
        int tmo_t    = -1;
        int busy_cnt = 0;
        int oe_cnt   = 0;
        int bad_data = 0;
        int bad_oe   = 0;
        int pulses   = 0;
        int inv      = 0;
        bit ended    = 1'b0;
        bit acked;
        int exp_off;
        acked   = (ack_at >= 1) && (ack_at <= TIMEOUT + 1);
        exp_off = acked ? (SETUP_CYC + 1 + ack_at) : (SETUP_CYC + 2 + TIMEOUT);
        accum       = d;
        sto_addr    = a;
        accum_valid = 1'b1;
        sto_req     = 1'b1;
        mem_ack     = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk1);
            #1;
            if (t == 0 && !hold_req) sto_req = 1'b0;
            if (perturb) begin
                accum    = 8'hFF;
                sto_addr = ADDR_W'($urandom);
            end
            if (t + 1 <= SETUP_CYC + 1) mem_ack = 1'($urandom);
            else                        mem_ack = (t + 1 == SETUP_CYC + 1 + ack_at);
            @(negedge clk1);
            if (mem_wr) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = t;
            end
            if (done) begin
                pulses++;
                if (done_t < 0) done_t = t;
            end
            if (err_timeout) begin
                pulses++;
                if (tmo_t < 0) tmo_t = t;
            end
            if (err_invalid) inv++;
            if (busy) busy_cnt++;
            if (data_oe) oe_cnt++;
            if (data_oe && (mem_wdata !== d || mem_addr !== a)) bad_data++;
            if (mem_wr && !data_oe) bad_oe++;
            if (done || err_timeout) sto_req = 1'b0;
            if (t > 0 && !busy) begin
                ended = 1'b1;
                break;
            end
        end
        mem_ack = 1'b0;
        sto_req = 1'b0;
        chk({tag, "_ended"},    32'(ended), 32'd1);
        chk({tag, "_first_wr"}, first_wr, SETUP_CYC + 1);
        chk({tag, "_wr_cycles"}, wr_cnt, acked ? ack_at : TIMEOUT + 1);
        chk({tag, "_done_t"},   done_t, acked ? exp_off : -1);
        chk({tag, "_tmo_t"},    tmo_t, acked ? -1 : exp_off);
        chk({tag, "_pulses"},   pulses, 1);
        chk({tag, "_busy_cyc"}, busy_cnt, exp_off + 1);
        chk({tag, "_oe_cyc"},   oe_cnt, exp_off + 1);
        chk({tag, "_data"},     bad_data, 0);
        chk({tag, "_wr_no_oe"}, bad_oe, 0);
        chk({tag, "_inv"},      inv, 0);
    endtask

    initial begin
        rst         = 1'b1;
        accum       = '0;
        accum_valid = 1'b0;
        sto_req     = 1'b0;
        sto_addr    = '0;
        mem_ack     = 1'b0;
        repeat (3) @(negedge clk1);

        // Reset state
        chk("rst_ctl", {26'd0, mem_wr, data_oe, busy, done, err_invalid, err_timeout}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        @(posedge clk1);
        #1 rst = 1'b0;
        @(negedge clk1);

        // Basic store with ack in the first WRITE cycle
        do_store(8'hA5, 13'h0100, 1, 1'b0, 1'b0, "basic");

        // Refused store: accumulator not valid
        accum_valid = 1'b0;
        accum       = 8'h77;
        sto_req     = 1'b1;
        @(posedge clk1);
        #1 sto_req = 1'b0;
        @(negedge clk1);
        chk("inv_pulse", 32'(err_invalid), 32'd1);
        chk("inv_quiet", {29'd0, mem_wr, data_oe, busy}, 32'd0);
        @(negedge clk1);
        chk("inv_1cyc", {28'd0, err_invalid, mem_wr, data_oe, busy}, 32'd0);

        // Timeout, and ack landing exactly on the terminal count, and one late ack
        do_store(8'h5A, 13'h1ABC, 0, 1'b0, 1'b0, "timeout");
        do_store(8'hC3, 13'h0F0F, TIMEOUT + 1, 1'b0, 1'b0, "ack_at_tc");
        do_store(8'h11, 13'h0222, TIMEOUT + 2, 1'b0, 1'b0, "ack_late");

        // Snapshot: inputs change after acceptance, request held while busy
        do_store(8'h3C, 13'h0ABC, 3, 1'b1, 1'b1, "snapshot");

        // Reset asserted between edges in the middle of a write
        accum_valid = 1'b1;
        accum       = 8'h5A;
        sto_addr    = 13'h0033;
        sto_req     = 1'b1;
        @(posedge clk1);
        #1 sto_req = 1'b0;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        chk("midrst_pre_wr", 32'(mem_wr), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_async", {27'd0, mem_wr, data_oe, busy, done, err_timeout}, 32'd0);
        @(posedge clk1);
        #1 rst = 1'b0;
        @(negedge clk1);
        do_store(8'h96, 13'h1001, 2, 1'b0, 1'b0, "post_rst");

        // Randomized transactions
        for (int i = 0; i < 10; i++) begin
            do_store(8'($urandom), ADDR_W'($urandom), int'($urandom_range(0, TIMEOUT + 3)),
                     1'($urandom), 1'($urandom), "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
